// File: rtl/nibble_serial_adder.sv
// Serial adder/subtractor that handles one 4-bit carry-select slice per clock,
// starting at the least significant slice, with a start/busy/done handshake.

module nsa_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] s0, s1;

    // Both carry-in cases are formed in parallel; the registered carry picks one.
    assign s0 = {1'b0, a} + {1'b0, b};
    assign s1 = {1'b0, a} + {1'b0, b} + 5'd1;
    assign {co, s} = ci ? s1 : s0;
endmodule

module nibble_serial_adder #(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nstate;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [KW-1:0]    k;
    logic [KW+1:0]    idx;
    logic             accept, last;
    logic [3:0]       sl_s;
    logic             sl_co;

    assign idx    = {k, 2'b00};
    assign last   = (k == KW'(NSLICE - 1));
    assign accept = start && (state != RUN);

    nsa_slice u_slice (
        .a  (opa[idx +: 4]),
        .b  (opb[idx +: 4]),
        .ci (carry),
        .s  (sl_s),
        .co (sl_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = RUN;
            RUN:     if (last)  nstate = DONE;
            DONE:    nstate = start ? RUN : IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Subtraction is folded into the add: B is inverted at capture and the +1 rides on the carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            sum[idx +: 4] <= sl_s;
            carry         <= sl_co;
            if (last) cout <= sl_co;
            else      k    <= k + 1'b1;
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against a plain-arithmetic model.

module tb_nibble_serial_adder;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout, busy, done;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic c, input logic s);
        if (s) return {1'b0, x} - {1'b0, y} + (WIDTH+1)'(1 << WIDTH);
        else   return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
    endfunction

    // Counts edges until done, sampling 1 time unit after each edge.
    task automatic wait_done(input bit disturb, output int n, output int nb);
        bit got;
        n = 0; nb = 0; got = 0;
        while (!got && n < 20) begin
            if (busy) nb++;
            if (disturb && n == 1) begin
                start = 1'b1; a = '1; b = '1; cin = 1'b1;
            end
            if (disturb && n == 2) start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done) got = 1;
        end
        if (!got) chk("timeout", 32'(n), 32'(NSLICE));
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic c, input logic s, input bit disturb);
        logic [WIDTH:0] exp;
        int n, nb;
        exp = ref_op(x, y, c, s);
        @(negedge clk);
        a = x; b = y; cin = c; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(disturb, n, nb);
        chk({tag, "_lat"},  32'(n),  32'(NSLICE));
        chk({tag, "_busy"}, 32'(nb), 32'(NSLICE));
        chk({tag, "_sum"},  32'(sum),  32'(exp[WIDTH-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(exp[WIDTH]));
        if (s) chk({tag, "_noborrow"}, 32'(cout), 32'(x >= y));
    endtask

    initial begin
        int n, nb;
        logic [WIDTH-1:0] ra, rb;
        logic rc, rs;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;

        run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op("ripcin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        run_op("sub1", 16'h0007, 16'h0005, 1'b0, 1'b1, 0);
        run_op("sub2", 16'h0005, 16'h0007, 1'b1, 1'b1, 0);

        run_op("ign", 16'h1111, 16'h2222, 1'b0, 1'b0, 1);
        chk("ign_sum_exact", 32'(sum), 32'h3333);
        @(posedge clk); #1;
        chk("ign_single_done", 32'(done), 0);
        chk("ign_idle_busy", 32'(busy), 0);

        // Reset in the middle of an operation discards the partial result.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_cout", 32'(cout), 0);
        rst_n = 1'b1;
        run_op("post_rst", 16'h000F, 16'h0001, 1'b0, 1'b0, 0);
        chk("post_rst_val", 32'(sum), 32'h0010);

        // Back-to-back: start held through the DONE cycle.
        run_op("b2b1", 16'h1111, 16'h2222, 1'b0, 1'b0, 0);
        a = 16'h8000; b = 16'h8000; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_started", 32'(busy), 1);
        wait_done(0, n, nb);
        chk("b2b_gap", 32'(n + 1), 5);
        chk("b2b_sum", 32'(sum), 32'h0000);
        chk("b2b_cout", 32'(cout), 1);

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op("rnd", ra, rb, rc, rs, (i % 5 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
